// File: rtl/cache_port_arbiter.sv
// Four-requester round-robin arbiter in front of a single shared cache port.
// One transaction is in flight at a time. A write finishes when the port
// accepts it and also updates the live-value table (LVT). A read finishes
// when the in-order read data comes back from the cache.

// Per-accelerator strobe slice. It turns the shared accept and response
// events into the one-hot strobes seen by the granted requester.
module cpa_lane (
    input  logic sel,
    input  logic accept,
    input  logic rsp_hit,
    output logic ready,
    output logic rsp_valid
);
    assign ready     = sel & accept;
    assign rsp_valid = sel & rsp_hit;
endmodule

module cache_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [3:0]             req_valid,
    input  logic [3:0]             req_we,
    input  logic [3:0][ADDR_W-1:0] req_addr,
    input  logic [3:0][DATA_W-1:0] req_wdata,
    output logic [3:0]             req_ready,
    output logic [3:0]             rsp_valid,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   port_valid,
    output logic                   port_we,
    output logic [ADDR_W-1:0]      port_addr,
    output logic [DATA_W-1:0]      port_wdata,
    input  logic                   port_ready,
    input  logic                   port_rvalid,
    input  logic [DATA_W-1:0]      port_rdata,
    output logic                   lvt_we,
    output logic [ADDR_W-1:0]      lvt_addr,
    output logic [1:0]             lvt_entry,
    output logic                   err_unexp
);
    localparam int NUM_PORTS = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2
    } state_t;

    state_t     state, state_nx;
    logic [1:0] grant_id, last_id, rr_id, cand;
    logic       rr_hit, accept, rsp_hit;

    // Round-robin pick: the search starts just after the last served requester
    // and wraps around, so the requester served most recently is checked last.
    always_comb begin
        rr_hit = 1'b0;
        rr_id  = last_id;
        cand   = last_id;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            cand = last_id + 2'(k);
            if (!rr_hit && req_valid[cand]) begin
                rr_hit = 1'b1;
                rr_id  = cand;
            end
        end
    end

    // Next state and port, LVT and response outputs. Every output is zero
    // outside the phase that qualifies it, so IDLE and reset drive all zeros.
    always_comb begin
        state_nx   = state;
        port_valid = 1'b0;
        port_we    = 1'b0;
        port_addr  = '0;
        port_wdata = '0;
        lvt_we     = 1'b0;
        lvt_addr   = '0;
        lvt_entry  = 2'd0;
        rsp_rdata  = '0;
        accept     = 1'b0;
        rsp_hit    = 1'b0;
        case (state)
            IDLE: begin
                if (rr_hit) state_nx = ISSUE;
            end
            ISSUE: begin
                // The port fields come from the latched grant, not from
                // req_valid. A requester that drops its valid is still served.
                port_valid = 1'b1;
                port_we    = req_we[grant_id];
                port_addr  = req_addr[grant_id];
                port_wdata = req_wdata[grant_id];
                if (port_ready) begin
                    accept = 1'b1;
                    if (req_we[grant_id]) begin
                        lvt_we    = 1'b1;
                        lvt_addr  = req_addr[grant_id];
                        lvt_entry = grant_id;
                        state_nx  = IDLE;
                    end else begin
                        state_nx  = WAIT_RD;
                    end
                end
            end
            WAIT_RD: begin
                if (port_rvalid) begin
                    rsp_hit   = 1'b1;
                    rsp_rdata = port_rdata;
                    state_nx  = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Latch the winner when leaving IDLE. last_id moves only on acceptance.
    // last_id resets to 3 so that ACCEL_0 has first priority.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_id <= 2'd0;
            last_id  <= 2'd3;
        end else begin
            if (state == IDLE && rr_hit) grant_id <= rr_id;
            if (accept)                  last_id  <= grant_id;
        end
    end

    // Sticky flag for read data that arrives with no read outstanding.
    // This includes returns for reads that a reset aborted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                           err_unexp <= 1'b0;
        else if (port_rvalid && state != WAIT_RD) err_unexp <= 1'b1;
    end

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_lane
        cpa_lane u_lane (
            .sel       (grant_id == 2'(i)),
            .accept    (accept),
            .rsp_hit   (rsp_hit),
            .ready     (req_ready[i]),
            .rsp_valid (rsp_valid[i])
        );
    end
endmodule

// File: doc/cache_port_arbiter.md
CACHE_PORT_ARBITER -- requirements
Module: cache_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, word-address width of the shared cache port.
REQ-002 Parameter DATA_W, default 32, data word width (matches `WORD).
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low. Ports are clk (input, 1, rising-edge clock) and reset_n (input, 1, asynchronous active-low reset).
REQ-004 req_valid  input  4  per-accelerator request valid; bit i is ACCEL_i.
REQ-005 req_we  input  4  per-accelerator write enable; 1 = write, 0 = read.
REQ-006 req_addr  input  4*ADDR_W  per-accelerator address; slice i is ACCEL_i.
REQ-007 req_wdata  input  4*DATA_W  per-accelerator write data.
REQ-008 req_ready  output  4  one-hot accept strobe to the granted accelerator.
REQ-009 rsp_valid  output  4  one-hot read-data-valid strobe to the requester.
REQ-010 rsp_rdata  output  DATA_W  read data, shared by all requesters, qualified by rsp_valid.
REQ-011 port_valid, port_we, port_addr, port_wdata  output  1/1/ADDR_W/DATA_W  shared cache port request.
REQ-012 port_ready  input  1  cache port accepts the request in the current cycle.
REQ-013 port_rvalid, port_rdata  input  1/DATA_W  cache read return, in order, at most one outstanding.
REQ-014 lvt_we, lvt_addr, lvt_entry  output  1/ADDR_W/2  LVT update: the address was last written by ACCEL_lvt_entry.

Function
REQ-015 States are IDLE, ISSUE, and WAIT_RD, encoded in a 2-bit register.
REQ-016 IDLE: if any req_valid is set, latch the round-robin winner into grant_id and go to ISSUE the next cycle.
REQ-017 Round-robin: the search starts at (last_id+1) mod 4 and ascends with wrap; last_id updates to grant_id on acceptance.
REQ-018 ISSUE: port_valid=1, and port_we, port_addr and port_wdata are driven combinationally from slice grant_id.
REQ-019 ISSUE with port_valid and port_ready both high (acceptance): req_ready[grant_id]=1 for exactly that cycle.
REQ-020 On write acceptance: lvt_we=1 in the same cycle, with lvt_addr=port_addr and lvt_entry=grant_id. The next state is IDLE.
REQ-021 On read acceptance: no LVT update. The next state is WAIT_RD.
REQ-022 ISSUE while port_ready=0: hold grant_id and all port fields stable. Grant is never withdrawn; requesters hold their request until req_ready.
REQ-023 WAIT_RD on port_rvalid=1: rsp_valid[grant_id]=1, rsp_rdata=port_rdata (combinational pass-through), next state IDLE.
REQ-024 port_rvalid in IDLE or ISSUE is ignored and raises the sticky error flag err_unexp (output, 1 bit).
REQ-025 Minimum latency: request to port_valid is 1 cycle. Back-to-back accepted writes are every 2 cycles, because IDLE is visited between grants.
REQ-026 A requester that drops req_valid while granted in ISSUE is still served. Grant is based on the latched grant_id.
REQ-027 Simultaneous port_ready and a new req_valid: the new request is arbitrated in the following IDLE cycle.
REQ-028 req_ready, rsp_valid, port_valid and lvt_we are all 0 in IDLE and whenever reset_n=0.

Reset
REQ-029 While reset_n=0: state=IDLE, grant_id=0, last_id=3 (so ACCEL_0 has first priority), err_unexp=0, and all outputs are 0.
REQ-030 Reset asserted mid-ISSUE or mid-WAIT_RD aborts the transaction. A later port_rvalid then sets err_unexp.
REQ-031 After reset_n deasserts, the first arbitration happens in the first clk edge where req_valid is nonzero.

Verification
REQ-032 req_valid=4'b1111, all writes, port_ready=1: grant order is 0,1,2,3,0, each 2 cycles apart. lvt_entry follows 0,1,2,3 and lvt_addr matches each req_addr.
REQ-033 ACCEL_2 reads address 0x40, port_ready held low 3 cycles: port_addr=0x40 stays stable 4 cycles, then req_ready=4'b0100. port_rvalid arrives with 0xDEADBEEF: rsp_valid=4'b0100 and rsp_rdata=0xDEADBEEF. lvt_we stays 0.
REQ-034 ACCEL_1 writes 0x10, then ACCEL_3 writes 0x10: lvt_entry goes 1 then 3 at lvt_addr=0x10.
REQ-035 Reset pulse while in WAIT_RD, then port_rvalid=1: no rsp_valid is asserted, err_unexp=1, state=IDLE.
REQ-036 After reset, req_valid=4'b1001: ACCEL_0 is granted first, then ACCEL_3.
